// File: rtl/maze_grid_pkg.sv
// Shared constants, link FSM encoding and tile palette for the maze grid renderer.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package maze_grid_pkg;

  localparam int GRID_COLS  = 4;
  localparam int GRID_ROWS  = 5;
  localparam int TILE_SHIFT = 6;
  localparam int ROW_W      = 3;
  localparam int COL_W      = 2;
  localparam int TILE_W     = 3;
  localparam int FRAME_W    = ROW_W + COL_W + TILE_W;

  // RGB 3-3-2 colours
  localparam logic [7:0] BORDER_COLOR = 8'b000_000_00;
  localparam logic [7:0] LINE_COLOR   = 8'b000_000_11;

  // Tile states as sent by the Arduino
  localparam logic [TILE_W-1:0] TILE_UNEXPLORED = 3'd0;
  localparam logic [TILE_W-1:0] TILE_VISITED    = 3'd1;
  localparam logic [TILE_W-1:0] TILE_ROBOT      = 3'd2;
  localparam logic [TILE_W-1:0] TILE_WALL       = 3'd3;
  localparam logic [TILE_W-1:0] TILE_TREASURE   = 3'd4;
  localparam logic [TILE_W-1:0] TILE_5          = 3'd5;
  localparam logic [TILE_W-1:0] TILE_6          = 3'd6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } link_state_t;

  // Synchronised view of one link wire
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } sync_t;

  // Tile state to display colour
  function automatic logic [7:0] tile_palette(input logic [TILE_W-1:0] tile);
    logic [7:0] color;
    case (tile)
      TILE_UNEXPLORED: color = 8'b100_100_10; // grey
      TILE_VISITED:    color = 8'b111_111_11; // white
      TILE_ROBOT:      color = 8'b111_000_00; // red
      TILE_WALL:       color = 8'b000_000_11; // blue
      TILE_TREASURE:   color = 8'b111_111_00; // yellow
      TILE_5:          color = 8'b000_111_00; // green
      TILE_6:          color = 8'b111_000_11; // magenta
      default:         color = 8'b000_111_11; // cyan
    endcase
    return color;
  endfunction

endpackage

// File: rtl/maze_grid_renderer_link_rx_sync.sv
// Brings one asynchronous link wire into the CLOCK domain and flags its edges.
// Latency: 2 cycles to level, edge pulse in the cycle the synchronised level changes.
// Backpressure: none; the sender must hold each level for at least 3 cycles.
import maze_grid_pkg::*;

module link_rx_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic  CLOCK,
  input  logic  RESET,
  input  logic  din,
  output sync_t sync
);

  logic meta_q;
  logic stable_q;
  logic prev_q;

  // Two-flop synchroniser followed by a history flop for edge detection
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      meta_q   <= RST_VAL;
      stable_q <= RST_VAL;
      prev_q   <= RST_VAL;
    end else begin
      meta_q   <= din;
      stable_q <= meta_q;
      prev_q   <= stable_q;
    end
  end

  assign sync.level = stable_q;
  assign sync.rise  = stable_q & ~prev_q;
  assign sync.fall  = ~stable_q & prev_q;

endmodule

// File: rtl/maze_grid_renderer.sv
// Maze tile renderer: serial-link tile writes, pixel coordinate to tile colour (GRID_LINES_EN adds grid lines).
// Latency: PIXEL_COLOR is registered, 1 cycle after PIXEL_X/PIXEL_Y; a tile write commits 4 cycles after CS_N rises.
// Backpressure: none; pixels stream every cycle and malformed link frames are dropped with a FRAME_ERR pulse.
import maze_grid_pkg::*;

module maze_grid_renderer (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [9:0]         PIXEL_X,
  input  logic [9:0]         PIXEL_Y,
  output logic [7:0]         PIXEL_COLOR,
  input  logic               LINK_CLK,
  input  logic               LINK_DATA,
  input  logic               LINK_CS_N,
  output logic               FRAME_DONE,
  output logic               FRAME_ERR,
  output logic [FRAME_W-1:0] LAST_FRAME
);

  sync_t clk_s;
  sync_t dat_s;
  sync_t cs_s;

  link_rx_sync #(.RST_VAL(1'b0)) u_clk_sync (.CLOCK(CLOCK), .RESET(RESET), .din(LINK_CLK),  .sync(clk_s));
  link_rx_sync #(.RST_VAL(1'b0)) u_dat_sync (.CLOCK(CLOCK), .RESET(RESET), .din(LINK_DATA), .sync(dat_s));
  link_rx_sync #(.RST_VAL(1'b1)) u_cs_sync  (.CLOCK(CLOCK), .RESET(RESET), .din(LINK_CS_N), .sync(cs_s));

  link_state_t state_q, state_nxt;
  logic [FRAME_W-1:0] shift_q;
  logic [3:0]         bit_cnt_q;
  logic [TILE_W-1:0]  tile_mem [GRID_ROWS][GRID_COLS];

  logic [ROW_W-1:0]  frm_row;
  logic [COL_W-1:0]  frm_col;
  logic [TILE_W-1:0] frm_tile;
  logic              frame_ok;
  logic              do_clear, do_shift, do_err, do_commit;

  assign frm_row  = shift_q[FRAME_W-1 -: ROW_W];
  assign frm_col  = shift_q[TILE_W +: COL_W];
  assign frm_tile = shift_q[TILE_W-1:0];
  // A 9 in the counter means more than FRAME_W bits arrived
  assign frame_ok = (bit_cnt_q == 4'd8) &&
                    (4'(frm_row) < 4'(GRID_ROWS)) &&
                    (4'(frm_col) < 4'(GRID_COLS));

  // Link FSM state register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Link FSM next state; CS_N rise wins over a coincident LINK_CLK rise
  always_comb begin
    state_nxt = state_q;
    do_clear  = 1'b0;
    do_shift  = 1'b0;
    do_err    = 1'b0;
    do_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_s.fall) begin
          state_nxt = SHIFT;
          do_clear  = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s.rise) begin
          if (frame_ok) begin
            state_nxt = COMMIT;
          end else begin
            state_nxt = IDLE;
            do_err    = 1'b1;
          end
        end else if (clk_s.rise) begin
          do_shift = 1'b1;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame shifter, tile memory and status pulses
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      LAST_FRAME <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      for (int r = 0; r < GRID_ROWS; r++)
        for (int c = 0; c < GRID_COLS; c++)
          tile_mem[r][c] <= TILE_UNEXPLORED;
    end else begin
      FRAME_DONE <= do_commit;
      FRAME_ERR  <= do_err;
      if (do_clear) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else if (do_shift) begin
        shift_q   <= {shift_q[FRAME_W-2:0], dat_s.level};
        bit_cnt_q <= (bit_cnt_q == 4'd9) ? 4'd9 : bit_cnt_q + 4'd1;
      end
      if (do_commit) begin
        tile_mem[frm_row][frm_col] <= frm_tile;
        LAST_FRAME                 <= shift_q;
      end
    end
  end

  logic [3:0] px_col;
  logic [3:0] px_row;
  logic       in_grid;
  logic [7:0] pix_color;

  assign px_col  = PIXEL_X[9:TILE_SHIFT];
  assign px_row  = PIXEL_Y[9:TILE_SHIFT];
  assign in_grid = (px_col < 4'(GRID_COLS)) && (px_row < 4'(GRID_ROWS));

  // Pixel colour lookup; reads the memory before any same-cycle commit lands
  always_comb begin
    pix_color = BORDER_COLOR;
    if (in_grid) begin
      pix_color = tile_palette(tile_mem[px_row[ROW_W-1:0]][px_col[COL_W-1:0]]);
`ifdef GRID_LINES_EN
      if ((PIXEL_X[TILE_SHIFT-1:0] == '0) || (PIXEL_Y[TILE_SHIFT-1:0] == '0))
        pix_color = LINE_COLOR;
`endif
    end
  end

  // Output colour register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) PIXEL_COLOR <= BORDER_COLOR;
    else       PIXEL_COLOR <= pix_color;
  end

endmodule
